// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter
// Round-robin front end for a shared sync_fifo_spram: NPORT valid/ready
// producers are arbitrated onto the FIFO write port, and the FIFO read port
// is drained through a 2-entry skid buffer that absorbs the FIFO's 1-cycle
// read latency, so a single valid/ready consumer can run at full rate.
//
// Build option: define FIFO_ARB_PRIO_EN to give port 0 strict priority.
// Ports 1..NPORT-1 then round-robin among themselves, and port-0 grants
// leave the round-robin pointer untouched. Without the macro, all ports
// share one round-robin ring.
module fifo_port_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NPORT = 4,
  localparam int PW    = $clog2(NPORT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // producer side
  input  logic [NPORT-1:0]       in_valid,
  input  logic [NPORT*WIDTH-1:0] in_data,
  output logic [NPORT-1:0]       in_ready,
  // FIFO write port
  output logic                   fifo_wr,
  output logic [WIDTH-1:0]       fifo_din,
  input  logic                   fifo_full,
  // FIFO read port
  output logic                   fifo_rd,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  // consumer side
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [PW-1:0]          grant_id
);

  typedef logic [WIDTH-1:0] word_t;

  word_t         port_data [NPORT];

  // write-side arbitration
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;
  logic          accept;

  // read-side skid buffer, skid_q[0] is the oldest word
  logic          rd_q;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  word_t         skid_q [2];
  word_t         skid_d [2];
  logic          pop;
  logic [2:0]    occ;

  // Present the flat producer bus as one word per port.
  for (genvar g = 0; g < NPORT; g++) begin : g_unpack
    assign port_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Pick the first requesting port at or after rr_ptr, wrapping modulo NPORT.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned; that is what keeps this block free of latches.
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NPORT; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NPORT)) begin
        scan_sum = scan_sum - (PW+1)'(NPORT);
      end
      scan_idx = scan_sum[PW-1:0];
`ifdef FIFO_ARB_PRIO_EN
      // Port 0 is handled outside the ring.
      if (!win_found && (scan_idx != '0) && in_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
`else
      if (!win_found && in_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
`endif
    end
`ifdef FIFO_ARB_PRIO_EN
    if (in_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // Grant the winner when the FIFO has room; advance the pointer past it.
  always_comb begin
    // While rst_n is low the FIFO is being cleared, so no write is offered.
    accept   = rst_n & win_found & ~fifo_full;
    in_ready = '0;
    if (accept) begin
      in_ready[win_idx] = 1'b1;
    end
    fifo_wr  = accept;
    fifo_din = win_found ? port_data[win_idx] : '0;
    grant_id = accept ? win_idx : '0;

    rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_PRIO_EN
    if (accept && (win_idx != '0)) begin
`else
    if (accept) begin
`endif
      rr_ptr_d = (win_idx == PW'(NPORT - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Issue FIFO reads only while the skid buffer can take the returning word.
  always_comb begin
    out_valid = (buf_cnt_q != 2'd0);
    out_data  = skid_q[0];
    pop       = out_valid & out_ready;
    // Words already held plus the one in flight, minus the one leaving now.
    occ       = 3'(buf_cnt_q) + 3'(rd_q) - 3'(pop);
    fifo_rd   = rst_n & ~fifo_empty & (occ < 3'd2);
  end

  // Skid buffer next state: pop first, then append the returning FIFO word.
  always_comb begin
    skid_d    = skid_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      skid_d[0] = skid_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (rd_q) begin
      if (buf_cnt_d == 2'd0) begin
        skid_d[0] = fifo_dout;
      end else begin
        skid_d[1] = fifo_dout;
      end
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  // State registers; reset discards any in-flight read and buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      rd_q      <= 1'b0;
      buf_cnt_q <= 2'd0;
      // NOTE: the two skid entries are reset (unlike a RAM) because skid_q[0]
      // drives out_data directly and must read 0 out of reset.
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      rr_ptr_q  <= rr_ptr_d;
      rd_q      <= fifo_rd;
      buf_cnt_q <= buf_cnt_d;
      skid_q    <= skid_d;
    end
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb_fifo_port_arbiter
// Directed and random stimulus for fifo_port_arbiter around a behavioural
// 15-deep FIFO. Accepted words are pushed to a scoreboard queue and compared
// in order when the consumer takes them; arbitration is compared every cycle
// against an independent round-robin model.
module tb_fifo_port_arbiter;

  localparam int WIDTH = 32;
  localparam int NPORT = 4;
  localparam int PW    = $clog2(NPORT);
  localparam int DEPTH = 15;

  logic                   clk;
  logic                   rst_n;
  logic [NPORT-1:0]       in_valid;
  logic [NPORT*WIDTH-1:0] in_data;
  logic [NPORT-1:0]       in_ready;
  logic                   fifo_wr;
  logic [WIDTH-1:0]       fifo_din;
  logic                   fifo_full;
  logic                   fifo_rd;
  logic [WIDTH-1:0]       fifo_dout;
  logic                   fifo_empty;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [PW-1:0]          grant_id;

  fifo_port_arbiter #(.WIDTH(WIDTH), .NPORT(NPORT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural FIFO (registered read data) ----------------
  logic [WIDTH-1:0] fmem [DEPTH];
  int fcnt, frp, fwp;
  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt      <= 0;
      frp       <= 0;
      fwp       <= 0;
      fifo_dout <= '0;
    end else begin
      if (fifo_wr && !fifo_full) begin
        fmem[fwp] <= fifo_din;
        fwp       <= (fwp + 1) % DEPTH;
      end
      if (fifo_rd && !fifo_empty) begin
        fifo_dout <= fmem[frp];
        frp       <= (frp + 1) % DEPTH;
      end
      fcnt <= fcnt + int'(fifo_wr && !fifo_full) - int'(fifo_rd && !fifo_empty);
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] sb_q [$];
  int grant_log [$];
  int acc_log   [$];
  int out_log   [$];
  int cyc = 0;
  logic [NPORT-1:0] acc_mask = '0;
  int m_rr = 0;

  // Reference arbiter: scan the ring from the model pointer.
  task automatic model_winner(input logic [NPORT-1:0] v, input int rr,
                              output bit found, output int win);
    found = 1'b0;
    win   = 0;
`ifdef FIFO_ARB_PRIO_EN
    if (v[0]) begin
      found = 1'b1;
      return;
    end
`endif
    for (int off = 0; off < NPORT; off++) begin
      int p;
      p = (rr + off) % NPORT;
`ifdef FIFO_ARB_PRIO_EN
      if (p == 0) continue;
`endif
      if (v[p]) begin
        found = 1'b1;
        win   = p;
        return;
      end
    end
  endtask

  bit               m_found;
  int               m_win;
  bit               m_acc;
  logic [NPORT-1:0] m_ready;
  logic [WIDTH-1:0] m_data;

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_mask = '0;
    end else begin
      cyc++;
      model_winner(in_valid, m_rr, m_found, m_win);
      m_acc   = m_found && !fifo_full;
      m_ready = '0;
      if (m_acc) m_ready[m_win] = 1'b1;
      m_data  = m_found ? in_data[m_win*WIDTH +: WIDTH] : '0;
      check("in_ready", 64'(in_ready), 64'(m_ready));
      check("fifo_wr", 64'(fifo_wr), 64'(m_acc));
      check("grant_id", 64'(grant_id), m_acc ? 64'(m_win) : 64'd0);
      check("fifo_din", 64'(fifo_din), 64'(m_data));
      check("rd_while_empty", 64'(fifo_rd && fifo_empty), 64'd0);
      check("skid_bound", 64'((dut.buf_cnt_q + dut.rd_q) <= 2), 64'd1);
      acc_mask = m_ready;
      if (m_acc) begin
        sb_q.push_back(m_data);
        grant_log.push_back(m_win);
        acc_log.push_back(cyc);
`ifdef FIFO_ARB_PRIO_EN
        if (m_win != 0) m_rr = (m_win + 1) % NPORT;
`else
        m_rr = (m_win + 1) % NPORT;
`endif
      end
      if (out_valid && out_ready) begin
        out_log.push_back(cyc);
        if (sb_q.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
        else                  check("out_data", 64'(out_data), 64'(sb_q.pop_front()));
      end
    end
  end

  // Reset discards everything in flight, in the model as well.
  always @(negedge rst_n) begin
    sb_q.delete();
    m_rr = 0;
  end

  // ---------------- producer / consumer drivers ----------------
  int               rem  [NPORT];
  int               seq  [NPORT];
  logic [WIDTH-1:0] base [NPORT];
  bit allow_new = 1'b1;
  bit rand_in   = 1'b0;
  bit rand_out  = 1'b0;

  task automatic load(input int port, input int n, input logic [WIDTH-1:0] b);
    rem[port]  = n;
    seq[port]  = 0;
    base[port] = b;
  endtask

  // Advance one cycle: retire accepted words, then present the next ones.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NPORT; i++) begin
      bit keep, newv;
      if (acc_mask[i]) begin
        rem[i]--;
        seq[i]++;
      end
      keep = in_valid[i] && !acc_mask[i];
      newv = allow_new && (!rand_in || ($urandom_range(0, 1) == 1));
      in_valid[i] = (rem[i] > 0) && (keep || newv);
      in_data[i*WIDTH +: WIDTH] = base[i] + WIDTH'(seq[i]);
    end
    if (rand_out) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic bit all_done();
    bit d;
    d = (sb_q.size() == 0) && (in_valid == '0);
    if (allow_new) begin
      for (int i = 0; i < NPORT; i++) if (rem[i] != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic wait_drain(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (all_done()) break;
      step();
    end
    check(tag, 64'(all_done()), 64'd1);
    check({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  // Hard time limit in case a wait is ever mis-bounded.
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NPORT; i++) load(i, 0, '0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_fifo_wr", 64'(fifo_wr), 64'd0);
    check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: all ports valid continuously, consumer always ready -> 0,1,2,3,0,...
    out_ready = 1'b1;
    grant_log.delete();
    for (int i = 0; i < NPORT; i++) load(i, 8, WIDTH'(i) << 24);
    wait_drain("rr_drain", 200);
    check("rr_grants", 64'(grant_log.size()), 64'd32);
    for (int k = 0; k < 8; k++) check("rr_order", 64'(grant_log[k]), 64'(k % NPORT));

    // 2: single port, latency and full throughput.
    acc_log.delete();
    out_log.delete();
    load(2, 16, 32'hA5A5_0001);
    wait_drain("lat_drain", 200);
    check("lat_accepts", 64'(acc_log.size()), 64'd16);
    check("lat_outputs", 64'(out_log.size()), 64'd16);
    // Accept sampled before edge N, out_valid seen after edge N+2.
    check("lat_first", 64'(out_log[0] - acc_log[0]), 64'd3);
    check("lat_stream", 64'(out_log[15] - out_log[0]), 64'd15);

    // 3: consumer stalled until FIFO (15) and skid buffer (2) are full.
    out_ready = 1'b0;
    acc_log.delete();
    out_log.delete();
    load(1, 12, 32'h1100_0000);
    load(3, 12, 32'h3300_0000);
    repeat (30) step();
    check("full_accepts", 64'(acc_log.size()), 64'd17);
    check("full_flag", 64'(fifo_full), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_fifo_wr", 64'(fifo_wr), 64'd0);
    out_ready = 1'b1;
    wait_drain("full_drain", 200);
    check("full_outputs", 64'(out_log.size()), 64'd24);

    // 4: random producers and random consumer back-pressure.
    rand_in  = 1'b1;
    rand_out = 1'b1;
    for (int i = 0; i < NPORT; i++) load(i, 1 << 30, $urandom);
    repeat (20000) step();
    allow_new = 1'b0;
    rand_out  = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain", 400);
    allow_new = 1'b1;
    rand_in   = 1'b0;
    for (int i = 0; i < NPORT; i++) load(i, 0, '0);
    step();

    // 5: reset mid-stream with a full skid buffer.
    out_ready = 1'b0;
    load(0, 4, 32'h5000_0000);
    load(2, 4, 32'h5200_0000);
    for (int c = 0; c < 20; c++) begin
      if (dut.buf_cnt_q == 2'd2) break;
      step();
    end
    check("pre_rst_buf_cnt", 64'(dut.buf_cnt_q), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_fifo_rd", 64'(fifo_rd), 64'd0);
    check("mid_rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = '0;
    in_data  = '0;
    for (int i = 0; i < NPORT; i++) load(i, 0, '0);
    out_ready = 1'b1;
    grant_log.delete();
    for (int i = 0; i < NPORT; i++) load(i, 3, 32'h6000_0000 + (WIDTH'(i) << 16));
    wait_drain("post_rst_drain", 200);
    check("post_rst_first", 64'(grant_log[0]), 64'd0);
    check("post_rst_second", 64'(grant_log[1]), 64'd1);

`ifdef FIFO_ARB_PRIO_EN
    // 6: port 0 strict priority over a continuously requesting port 1.
    grant_log.delete();
    load(0, 6, 32'h7000_0000);
    load(1, 3, 32'h7100_0000);
    wait_drain("prio_drain", 200);
    for (int k = 0; k < 6; k++) check("prio_port0", 64'(grant_log[k]), 64'd0);
    check("prio_port1", 64'(grant_log[6]), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
